// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constant stage-control patterns for the pipeline hazard sequencer.
// Stage order inside a control vector: PC, IF/ID, ID/EX, EX/MEM, MEM/WB (index 0..4).
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MDU_BUSY = 2'd1,
      MDU_DONE = 2'd2
   } ctrl_state_e;

   typedef struct packed {
      logic stall;
      logic flush;
   } stage_ctrl_t;

   localparam int NUM_STG   = 5;
   localparam int STG_PC    = 0;
   localparam int STG_IFID  = 1;
   localparam int STG_IDEX  = 2;
   localparam int STG_EXMEM = 3;
   localparam int STG_MEMWB = 4;

   typedef stage_ctrl_t [NUM_STG-1:0] ctrl_vec_t;

   // Each pair is {stall, flush}; leftmost pair is MEM/WB.
   localparam ctrl_vec_t FREEZE  = 10'b01_10_10_10_10;
   localparam ctrl_vec_t MDUHOLD = 10'b00_01_10_10_10;

   // True when any stage is asked to stall and flush at once.
   function automatic logic ctrl_conflict(input ctrl_vec_t v);
      logic c;
      c = 1'b0;
      for (int i = 0; i < NUM_STG; i++) c = c | (v[i].stall & v[i].flush);
      return c;
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: the EX load writes a register the ID instruction reads.
module load_use_detect #(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   output logic              load_use
);

   // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
   assign load_use = ex_mem_read && (ex_rd != '0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use, redirect, MUL/DIV occupancy
// and data-memory wait, plus the MDU start pulse and latency counter.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW  = 5,
   parameter int MDU_LAT = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_mdu,
   input  logic              ex_redirect,
   input  logic              mem_req,
   input  logic              mem_ready,
   output logic              pc_stall,
   output logic              ifid_stall,
   output logic              idex_stall,
   output logic              exmem_stall,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              exmem_flush,
   output logic              memwb_flush,
   output logic              mdu_start,
   output logic [1:0]        state_o
);

   localparam int CNT_W = $clog2(MDU_LAT);

   if (MDU_LAT < 2) begin : g_bad_lat
      $error("pipe_hazard_ctrl: MDU_LAT must be at least 2");
   end

   ctrl_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ctrl_vec_t        ctrl;
   logic             start;
   logic             load_use;
   logic             memstall;

   assign memstall = mem_req & ~mem_ready;

   load_use_detect #(.REG_AW(REG_AW)) u_load_use (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .ex_rd       (ex_rd),
      .ex_mem_read (ex_mem_read),
      .load_use    (load_use)
   );

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      ctrl    = '0;
      start   = 1'b0;
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == MDU_BUSY) cnt_d = cnt_q - CNT_W'(1);

      unique case (state_q)
         RUN: begin
            if (memstall) begin
               ctrl = FREEZE;
            end else if (ex_redirect) begin
               ctrl[STG_IFID].flush = 1'b1;
               ctrl[STG_IDEX].flush = 1'b1;
            end else if (ex_mdu) begin
               start   = 1'b1;
               ctrl    = MDUHOLD;
               cnt_d   = CNT_W'(MDU_LAT - 1);
               state_d = MDU_BUSY;
            end else if (load_use) begin
               ctrl[STG_PC].stall   = 1'b1;
               ctrl[STG_IFID].stall = 1'b1;
               ctrl[STG_IDEX].flush = 1'b1;
            end
         end
         MDU_BUSY: begin
            if (cnt_q == CNT_W'(1) && !memstall) begin
               state_d = RUN;
            end else if (cnt_q == CNT_W'(1)) begin
               ctrl    = FREEZE;
               state_d = MDU_DONE;
            end else begin
               ctrl = memstall ? FREEZE : MDUHOLD;
            end
         end
         MDU_DONE: begin
            if (memstall) ctrl = FREEZE;
            else          state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs are forced low while reset is held, whatever the inputs do.
   assign pc_stall    = reset_n & ctrl[STG_PC].stall;
   assign ifid_stall  = reset_n & ctrl[STG_IFID].stall;
   assign idex_stall  = reset_n & ctrl[STG_IDEX].stall;
   assign exmem_stall = reset_n & ctrl[STG_EXMEM].stall;
   assign ifid_flush  = reset_n & ctrl[STG_IFID].flush;
   assign idex_flush  = reset_n & ctrl[STG_IDEX].flush;
   assign exmem_flush = reset_n & ctrl[STG_EXMEM].flush;
   assign memwb_flush = reset_n & ctrl[STG_MEMWB].flush;
   assign mdu_start   = reset_n & start;
   assign state_o     = state_q;

   a_no_redirect_with_mdu: assert property (@(posedge clock) disable iff (!reset_n)
      !(ex_redirect && ex_mdu));

   a_stall_xor_flush: assert property (@(posedge clock) disable iff (!reset_n)
      !ctrl_conflict(ctrl));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: reset, load-use, redirect, MDU timing,
// memory wait interplay and reset during an MDU operation.
module tb_pipe_hazard_ctrl;

   localparam int REG_AW = 5;

   // Packed view {pc_s, ifid_s, idex_s, exmem_s, ifid_f, idex_f, exmem_f, memwb_f, mdu_start}
   localparam logic [8:0] O_IDLE    = 9'b0000_0000_0;
   localparam logic [8:0] O_FREEZE  = 9'b1111_0001_0;
   localparam logic [8:0] O_MDUHOLD = 9'b1110_0010_0;
   localparam logic [8:0] O_MDUSTRT = 9'b1110_0010_1;
   localparam logic [8:0] O_LOADUSE = 9'b1100_0100_0;
   localparam logic [8:0] O_REDIR   = 9'b0000_1100_0;

   logic              clock;
   logic              reset_n;
   logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
   logic              id_use_rs1, id_use_rs2, ex_mem_read, ex_mdu, ex_redirect;
   logic              mem_req, mem_ready;
   logic              pc_stall, ifid_stall, idex_stall, exmem_stall;
   logic              ifid_flush, idex_flush, exmem_flush, memwb_flush;
   logic              mdu_start;
   logic [1:0]        state_o;

   int n_assert;
   int n_fail;

   pipe_hazard_ctrl #(.REG_AW(REG_AW), .MDU_LAT(8)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .ex_rd       (ex_rd),
      .ex_mem_read (ex_mem_read),
      .ex_mdu      (ex_mdu),
      .ex_redirect (ex_redirect),
      .mem_req     (mem_req),
      .mem_ready   (mem_ready),
      .pc_stall    (pc_stall),
      .ifid_stall  (ifid_stall),
      .idex_stall  (idex_stall),
      .exmem_stall (exmem_stall),
      .ifid_flush  (ifid_flush),
      .idex_flush  (idex_flush),
      .exmem_flush (exmem_flush),
      .memwb_flush (memwb_flush),
      .mdu_start   (mdu_start),
      .state_o     (state_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [8:0] obs();
      return {pc_stall, ifid_stall, idex_stall, exmem_stall,
              ifid_flush, idex_flush, exmem_flush, memwb_flush, mdu_start};
   endfunction

   task automatic clear_inputs();
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
      id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
      ex_mdu = 1'b0; ex_redirect = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      mem_req = 1'b1; mem_ready = 1'b0; ex_mdu = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      n_assert++;
      if (obs() !== O_IDLE) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected %b", obs(), O_IDLE);
      end
      n_assert++;
      if (state_o !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_state: got %0d expected 0", state_o);
      end
      clear_inputs();
      reset_n = 1'b1;
      #1;
      n_assert++;
      if (obs() !== O_IDLE || state_o !== 2'd0) begin
         n_fail++;
         $display("FAIL post_reset: got %b/%0d expected %b/0", obs(), state_o, O_IDLE);
      end
      next_cycle();
   endtask

   task automatic test_load_use();
      clear_inputs();
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
      #1;
      n_assert++;
      if (obs() !== O_LOADUSE) begin
         n_fail++;
         $display("FAIL load_use_rs1: got %b expected %b", obs(), O_LOADUSE);
      end
      next_cycle();
      id_use_rs1 = 1'b0; id_rs2 = 5'd5; id_use_rs2 = 1'b1; id_rs1 = 5'd7;
      #1;
      n_assert++;
      if (obs() !== O_LOADUSE) begin
         n_fail++;
         $display("FAIL load_use_rs2: got %b expected %b", obs(), O_LOADUSE);
      end
      next_cycle();
      id_use_rs2 = 1'b0;
      #1;
      n_assert++;
      if (obs() !== O_IDLE) begin
         n_fail++;
         $display("FAIL load_use_not_read: got %b expected %b", obs(), O_IDLE);
      end
      next_cycle();
      ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
      #1;
      n_assert++;
      if (obs() !== O_IDLE) begin
         n_fail++;
         $display("FAIL load_use_x0: got %b expected %b", obs(), O_IDLE);
      end
      next_cycle();
      ex_rd = 5'd9; id_rs1 = 5'd9; ex_mem_read = 1'b0;
      #1;
      n_assert++;
      if (obs() !== O_IDLE) begin
         n_fail++;
         $display("FAIL load_use_not_load: got %b expected %b", obs(), O_IDLE);
      end
      next_cycle();
   endtask

   task automatic test_redirect();
      clear_inputs();
      ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
      ex_redirect = 1'b1;
      #1;
      n_assert++;
      if (obs() !== O_REDIR || state_o !== 2'd0) begin
         n_fail++;
         $display("FAIL redirect_over_load_use: got %b/%0d expected %b/0", obs(), state_o, O_REDIR);
      end
      next_cycle();
   endtask

   task automatic test_mdu();
      logic [8:0] exp_o;
      logic [1:0] exp_s;
      clear_inputs();
      ex_mdu = 1'b1;
      for (int c = 0; c <= 7; c++) begin
         #1;
         exp_o = (c == 0) ? O_MDUSTRT : (c == 7) ? O_IDLE : O_MDUHOLD;
         exp_s = (c == 0) ? 2'd0 : 2'd1;
         n_assert++;
         if (obs() !== exp_o || state_o !== exp_s) begin
            n_fail++;
            $display("FAIL mdu_cycle%0d: got %b/%0d expected %b/%0d", c, obs(), state_o, exp_o, exp_s);
         end
         next_cycle();
      end
      ex_mdu = 1'b0;
      #1;
      n_assert++;
      if (obs() !== O_IDLE || state_o !== 2'd0) begin
         n_fail++;
         $display("FAIL mdu_after: got %b/%0d expected %b/0", obs(), state_o, O_IDLE);
      end
      next_cycle();
   endtask

   task automatic test_mdu_memwait();
      logic [8:0] exp_o;
      logic [1:0] exp_s;
      clear_inputs();
      ex_mdu = 1'b1;
      for (int c = 0; c <= 11; c++) begin
         mem_req   = (c >= 5 && c <= 10);
         mem_ready = 1'b0;
         #1;
         if (c == 0)      exp_o = O_MDUSTRT;
         else if (c <= 4) exp_o = O_MDUHOLD;
         else if (c <= 10) exp_o = O_FREEZE;
         else             exp_o = O_IDLE;
         exp_s = (c == 0) ? 2'd0 : (c <= 7) ? 2'd1 : 2'd2;
         n_assert++;
         if (obs() !== exp_o || state_o !== exp_s) begin
            n_fail++;
            $display("FAIL mdu_wait_cycle%0d: got %b/%0d expected %b/%0d", c, obs(), state_o, exp_o, exp_s);
         end
         next_cycle();
      end
      clear_inputs();
      #1;
      n_assert++;
      if (obs() !== O_IDLE || state_o !== 2'd0) begin
         n_fail++;
         $display("FAIL mdu_wait_after: got %b/%0d expected %b/0", obs(), state_o, O_IDLE);
      end
      next_cycle();
   endtask

   task automatic test_memstall_redirect();
      clear_inputs();
      ex_redirect = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_assert++;
         if (obs() !== O_FREEZE) begin
            n_fail++;
            $display("FAIL memstall_redir_freeze%0d: got %b expected %b", c, obs(), O_FREEZE);
         end
         next_cycle();
      end
      mem_ready = 1'b1;
      #1;
      n_assert++;
      if (obs() !== O_REDIR) begin
         n_fail++;
         $display("FAIL memstall_redir_release: got %b expected %b", obs(), O_REDIR);
      end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_reset_mid_op();
      logic [8:0] exp_o;
      clear_inputs();
      ex_mdu = 1'b1;
      repeat (3) next_cycle();
      #2;
      reset_n = 1'b0;
      #1;
      n_assert++;
      if (obs() !== O_IDLE || state_o !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_mid_op: got %b/%0d expected %b/0", obs(), state_o, O_IDLE);
      end
      ex_mdu = 1'b0;
      next_cycle();
      reset_n = 1'b1;
      #1;
      n_assert++;
      if (obs() !== O_IDLE || state_o !== 2'd0 || mdu_start !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_op_release: got %b/%0d expected %b/0", obs(), state_o, O_IDLE);
      end
      next_cycle();
      // A fresh operation after the abort must still run the full latency.
      ex_mdu = 1'b1;
      for (int c = 0; c <= 7; c++) begin
         #1;
         exp_o = (c == 0) ? O_MDUSTRT : (c == 7) ? O_IDLE : O_MDUHOLD;
         n_assert++;
         if (obs() !== exp_o) begin
            n_fail++;
            $display("FAIL mdu_after_abort_cycle%0d: got %b expected %b", c, obs(), exp_o);
         end
         next_cycle();
      end
      clear_inputs();
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      clear_inputs();
      test_reset();
      test_load_use();
      test_redirect();
      test_mdu();
      test_mdu_memwait();
      test_memstall_redirect();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V core.
- Drives the stall and flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves four hazard sources: load-use, EX-stage redirect (branch/jump), multi-cycle MUL/DIV occupancy, and data-memory wait.
- Owns the MDU start pulse and the latency counter.

Parameters:
- REG_AW, 5, register-index width.
- MDU_LAT, 8, total cycles a MUL/DIV occupies EX, including its start cycle; must be ≥2 (elaboration assertion).
- CNT_W, $clog2(MDU_LAT), counter width (derived, not overridable).

Ports:
- clock  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  REG_AW  source indices of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  the ID instruction reads rs1 / rs2.
- ex_rd  in  REG_AW  destination of the instruction in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_mdu  in  1  the EX instruction is MUL/DIV.
- ex_redirect  in  1  EX resolved a taken branch or jump.
- mem_req  in  1  MEM stage has an outstanding data access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_stall, ifid_stall, idex_stall, exmem_stall  out  1  hold the register.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1  load a bubble (zero).
- mdu_start  out  1  one-cycle start pulse to the MDU.
- state_o  out  2  FSM state, for debug.

Behaviour:
- Flush wins over stall inside the pipeline register. Per register, at most one of stall/flush is asserted; otherwise the register advances.
- memstall = mem_req & ~mem_ready (combinational).
- FREEZE pattern:
  - pc/ifid/idex/exmem stall = 1 and memwb_flush = 1.
  - All other outputs 0, mdu_start = 0.
  - All ID/EX hazards are ignored while frozen.
- MDUHOLD pattern: pc/ifid/idex stall = 1, exmem_flush = 1.
- FSM states are RUN (0), MDU_BUSY (1) and MDU_DONE (2). Reset state is RUN and the counter resets to 0.
- While reset_n is low, every output is 0.
- RUN, in priority order:
  1. memstall → FREEZE.
  2. ex_redirect → ifid_flush = 1, idex_flush = 1, PC advances.
  3. ex_mdu → mdu_start = 1, MDUHOLD, cnt ← MDU_LAT-1, next state MDU_BUSY.
  4. Load-use → pc_stall = 1, ifid_stall = 1, idex_flush = 1. Load-use is ex_mem_read & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  5. Otherwise all outputs 0.
- MDU_BUSY: the counter decrements every cycle, independent of memstall. Each cycle, evaluate in this order:
  1. cnt==1 & ~memstall → release (all 0), next RUN. The EX result is latched into EX/MEM on this edge.
  2. cnt==1 & memstall → FREEZE, next MDU_DONE.
  3. Otherwise → FREEZE if memstall, else MDUHOLD.
- MDU_DONE: memstall → FREEZE; otherwise release and go to RUN.
- EX occupancy for a MUL/DIV is exactly MDU_LAT cycles when there is no memstall.
- ex_mdu and ex_redirect are ignored outside RUN. Upstream keeps them asserted while EX is held.
- A redirect or load-use arriving during FREEZE is acted on in the first cycle memstall drops.
- In the MDU release cycle, ex_mdu is still high but is not re-triggered: the state is not RUN.
- ex_redirect & ex_mdu together is illegal; flag it with an assertion.
- Deasserting reset_n mid-MDU returns to RUN with cnt = 0 and no mdu_start pulse.

Decomposition:
- pipe_ctrl_pkg:
  - ctrl_state_e {RUN, MDU_BUSY, MDU_DONE} (2-bit).
  - stage_ctrl_t struct {stall, flush}.
  - Helper constants FREEZE and MDUHOLD as stage_ctrl_t arrays.
- Sub-module load_use_detect: purely combinational comparator on the ID/EX fields, giving one output bit.
- The FSM and counter live in pipe_hazard_ctrl.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → pc_stall = ifid_stall = idex_flush = 1 for one cycle. With ex_rd=0 instead → no stall.
- Redirect with load-use present in the same cycle: ex_redirect=1 → ifid_flush = idex_flush = 1, pc_stall = 0.
- MDU, MDU_LAT=8, ex_mdu held:
  - mdu_start is high only in cycle 0.
  - MDUHOLD holds for cycles 0–6.
  - Cycle 7: all outputs 0, state_o returns to 0.
  - No second mdu_start pulse.
- MDU with mem wait: memstall held for cycles 5–10 of the MDU op → FREEZE for cycles 5–10, state goes to MDU_DONE at cycle 7, release in cycle 11.
- Memstall with redirect pending: mem_ready=0 for 3 cycles → FREEZE ×3 with idex_flush = 0; then ifid_flush = idex_flush = 1.
- Reset mid-op: drop reset_n during MDU_BUSY → all outputs 0 immediately. After release: state RUN, mdu_start = 0.
